// File: rtl/usb_slave_pkg.sv
// Shared types and constants for the USB command sequencer.
package usb_slave_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    DATA    = 3'd3,
    REG_WR  = 3'd4,
    MEM_WR  = 3'd5
  } state_e;

  // Header byte layout: bit7 selects the target, bits6:0 are unit count minus one
  localparam int TARGET_BIT = 7;
  localparam int CNT_MSB    = 6;
  localparam int CNT_W      = CNT_MSB + 1;

  // Bytes per memory word
  localparam int MEM_BYTES  = 4;
  localparam int BYTE_IDX_W = $clog2(MEM_BYTES);
  localparam int WORD_W     = 8 * MEM_BYTES;

endpackage

// File: rtl/usb_byte_packer.sv
// Packs a little-endian byte stream into memory words.
// Bytes shift in from the top, so after MEM_BYTES bytes the first byte
// sits in bits [7:0]; the most recent byte is always in the top lane.
module usb_byte_packer
  import usb_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0]     shreg_q, shreg_d;

  // This byte completes a word when it lands in the last lane
  assign word_done_o = byte_valid_i && (idx_q == BYTE_IDX_W'(MEM_BYTES - 1));
  assign word_o      = shreg_q;

  // Next-state: clear only rewinds the lane index, the word keeps its contents
  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      shreg_d = {byte_i, shreg_q[WORD_W-1:8]};
      idx_d   = word_done_o ? '0 : idx_q + BYTE_IDX_W'(1);
    end
  end

  // Packer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/usb_cmd_sequencer.sv
// Turns a USB command byte stream into register-file or memory writes.
module usb_cmd_sequencer
  import usb_slave_pkg::*;
#(
  parameter int MEM_AW = 16,
  parameter int REG_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              abort_i,
  output logic              reg_mem_o,
  output logic [31:0]       data_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              reg_we_o,
  output logic [REG_AW-1:0] reg_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e              state_q, state_d;
  logic                reg_mem_q, reg_mem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    units_q, units_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
  logic                done_q, done_d;

  logic                accept;
  logic                last_unit;
  logic                pack_valid;
  logic                pack_clr;
  logic                word_done;
  logic [WORD_W-1:0]   packed_word;

  // Abort wins over byte acceptance: a byte offered alongside abort is dropped
  assign in_ready_o = (state_q == IDLE) || (state_q == ADDR_HI) ||
                      (state_q == ADDR_LO) || (state_q == DATA);
  assign accept     = in_valid_i && in_ready_o && !abort_i;
  assign last_unit  = (units_q == cnt_q);
  assign pack_valid = accept && (state_q == DATA);
  assign pack_clr   = abort_i || (state_q == IDLE);

  usb_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pack_clr),
    .byte_valid_i (pack_valid),
    .byte_i       (in_data_i),
    .word_o       (packed_word),
    .word_done_o  (word_done)
  );

  // Register writes carry only the latest byte, which sits in the packer's top lane
  assign data_o     = reg_mem_q ? {24'b0, packed_word[WORD_W-1:WORD_W-8]} : packed_word;
  assign reg_mem_o  = reg_mem_q;
  assign mem_addr_o = mem_addr_q;
  assign reg_addr_o = reg_addr_q;
  assign reg_we_o   = (state_q == REG_WR);
  assign mem_req_o  = (state_q == MEM_WR);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

  // Next-state and datapath update for the frame sequencer
  always_comb begin
    state_d    = state_q;
    reg_mem_d  = reg_mem_q;
    cnt_d      = cnt_q;
    units_d    = units_q;
    addr_hi_d  = addr_hi_q;
    mem_addr_d = mem_addr_q;
    reg_addr_d = reg_addr_q;
    done_d     = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          reg_mem_d = in_data_i[TARGET_BIT];
          cnt_d     = in_data_i[CNT_MSB:0];
          units_d   = '0;
          state_d   = in_data_i[TARGET_BIT] ? ADDR_LO : ADDR_HI;
        end
        ADDR_HI: if (accept) begin
          addr_hi_d = in_data_i;
          state_d   = ADDR_LO;
        end
        ADDR_LO: if (accept) begin
          if (reg_mem_q) reg_addr_d = REG_AW'(in_data_i);
          else           mem_addr_d = MEM_AW'({addr_hi_q, in_data_i});
          state_d = DATA;
        end
        DATA: if (accept) begin
          if (reg_mem_q)      state_d = REG_WR;
          else if (word_done) state_d = MEM_WR;
        end
        REG_WR: begin
          reg_addr_d = reg_addr_q + REG_AW'(1);
          units_d    = units_q + CNT_W'(1);
          done_d     = last_unit;
          state_d    = last_unit ? IDLE : DATA;
        end
        MEM_WR: if (mem_gnt_i) begin
          mem_addr_d = mem_addr_q + MEM_AW'(1);
          units_d    = units_q + CNT_W'(1);
          done_d     = last_unit;
          state_d    = last_unit ? IDLE : DATA;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      reg_mem_q  <= 1'b0;
      cnt_q      <= '0;
      units_q    <= '0;
      addr_hi_q  <= '0;
      mem_addr_q <= '0;
      reg_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_mem_q  <= reg_mem_d;
      cnt_q      <= cnt_d;
      units_q    <= units_d;
      addr_hi_q  <= addr_hi_d;
      mem_addr_q <= mem_addr_d;
      reg_addr_q <= reg_addr_d;
      done_q     <= done_d;
    end
  end

endmodule
